// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver state encoding and the 3-sample majority vote.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_COMMIT   = 3'd5,
        ST_BRK_WAIT = 3'd6
    } rx_state_e;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser followed by a 3-deep sample history
// whose majority gives a glitch-filtered view of the serial line.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic rx_i,
    output logic voted_o
);

    logic [1:0] sync_q;
    logic [2:0] hist_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    assign voted_o = majority3(hist_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: N data bits, optional parity, 1/2 stop bits,
// majority-voted sampling, error/break flags and a valid/ready output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int FREQ      = 24_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun
);

    localparam int CPB  = FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STP_LAST = 4'(STOP_BITS - 1);

    if (CPB < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PAR_NONE ||
        PARITY > PAR_EVEN || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
        $error("uart_rx_cfg: illegal parameter combination");
    end

    logic voted;

    uart_rx_sampler u_sampler (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_i    (rx_serial),
        .voted_o (voted)
    );

    rx_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   zero_q, zero_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   brk_q, brk_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   oper_q, oper_d;
    logic                   ofer_q, ofer_d;
    logic                   obrk_q, obrk_d;
    logic                   ovr_q, ovr_d;
    logic                   par_x;

    // XOR of data plus received parity bit: 1 means an odd total of ones
    assign par_x = (^shift_q) ^ voted;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        zero_d  = zero_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        data_d  = data_q;
        valid_d = valid_q;
        oper_d  = oper_q;
        ofer_d  = ofer_q;
        obrk_d  = obrk_q;
        ovr_d   = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!voted) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (voted) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = '0;
                        zero_d  = 1'b1;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        brk_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {voted, shift_q[DATA_BITS-1:1]};
                    zero_d  = zero_q & ~voted;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = (PARITY == PAR_ODD) ? ~par_x : par_x;
                    zero_d  = zero_q & ~voted;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!voted) begin
                        ferr_d = 1'b1;
                    end
                    if (bit_q == STP_LAST) begin
                        brk_d   = zero_q & ~voted;
                        state_d = ST_COMMIT;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                cnt_d = '0;
                // A same-cycle handshake frees the slot, so the new word is never lost
                if (!valid_q || rx_ready) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    oper_d  = perr_q;
                    ofer_d  = ferr_q;
                    obrk_d  = brk_q;
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = brk_q ? ST_BRK_WAIT : ST_IDLE;
            end
            ST_BRK_WAIT: begin
                if (voted) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            oper_q  <= 1'b0;
            ofer_q  <= 1'b0;
            obrk_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            oper_q  <= oper_d;
            ofer_q  <= ofer_d;
            obrk_q  <= obrk_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame accumulators are reinitialised at every accepted start bit
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        zero_q  <= zero_d;
        perr_q  <= perr_d;
        ferr_q  <= ferr_d;
        brk_q   <= brk_d;
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = oper_q;
    assign rx_frame_err  = ofer_q;
    assign rx_break      = obrk_q;
    assign rx_overrun    = ovr_q;

endmodule
